control_unit: RTL and testbench

Hardwired Mini-SRC sequencer that drives the control inputs of the datapath. It runs a fetch/execute state machine, decodes the instruction presented from IR, and emits one-hot bus-source selects, register write strobes, ALU opcode and register-file addresses. It also acts as the initiator of a ready-handshake memory port; the datapath MDR captures memory data.

---
 rtl/cu_pkg.sv | 87 ++++++++
 rtl/control_unit_mem_handshake.sv | 42 ++++
 rtl/control_unit.sv | 243 ++++++++++++++++++++++++
 tb/tb_control_unit.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
`default_nettype none
// ============================================================================
// cu_pkg -- FSM states, opcodes, ALU codes and strobe bit positions for control_unit
// Rev 1.0
// ============================================================================
package cu_pkg;

    typedef enum logic [3:0] {
        ST_RESET, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7, ST_HALT, ST_FAULT
    } state_t;

    localparam logic [4:0] OP_LD   = 5'd0;
    localparam logic [4:0] OP_LDI  = 5'd1;
    localparam logic [4:0] OP_ST   = 5'd2;
    localparam logic [4:0] OP_ADD  = 5'd3;
    localparam logic [4:0] OP_SUB  = 5'd4;
    localparam logic [4:0] OP_AND  = 5'd5;
    localparam logic [4:0] OP_OR   = 5'd6;
    localparam logic [4:0] OP_SHR  = 5'd7;
    localparam logic [4:0] OP_SHL  = 5'd8;
    localparam logic [4:0] OP_ROR  = 5'd9;
    localparam logic [4:0] OP_ROL  = 5'd10;
    localparam logic [4:0] OP_ADDI = 5'd11;
    localparam logic [4:0] OP_ANDI = 5'd12;
    localparam logic [4:0] OP_ORI  = 5'd13;
    localparam logic [4:0] OP_MUL  = 5'd14;
    localparam logic [4:0] OP_DIV  = 5'd15;
    localparam logic [4:0] OP_JR   = 5'd16;
    localparam logic [4:0] OP_MFHI = 5'd17;
    localparam logic [4:0] OP_MFLO = 5'd18;
    localparam logic [4:0] OP_IN   = 5'd19;
    localparam logic [4:0] OP_OUT  = 5'd20;
    localparam logic [4:0] OP_NOP  = 5'd21;
    localparam logic [4:0] OP_HALT = 5'd22;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_SHR = 4'd4;
    localparam logic [3:0] ALU_SHL = 4'd5;
    localparam logic [3:0] ALU_ROR = 4'd6;
    localparam logic [3:0] ALU_ROL = 4'd7;
    localparam logic [3:0] ALU_MUL = 4'd8;
    localparam logic [3:0] ALU_DIV = 4'd9;

    localparam int RS_REGFILE = 0;
    localparam int RS_HI      = 1;
    localparam int RS_LO      = 2;
    localparam int RS_ZHI     = 3;
    localparam int RS_ZLO     = 4;
    localparam int RS_PC      = 5;
    localparam int RS_MDR     = 6;
    localparam int RS_INPORT  = 7;
    localparam int RS_C       = 8;

    localparam int WE_REGFILE = 0;
    localparam int WE_HI      = 1;
    localparam int WE_LO      = 2;
    localparam int WE_PC      = 3;
    localparam int WE_Z       = 4;
    localparam int WE_MDR     = 5;
    localparam int WE_IR      = 6;
    localparam int WE_Y       = 7;
    localparam int WE_MAR     = 8;
    localparam int WE_OUTPORT = 9;

    // Address-forming instructions (ld, ldi, st) fall through to ADD.
    function automatic logic [3:0] alu_code(input logic [4:0] op);
        logic [3:0] code;
        case (op)
            OP_SUB:          code = ALU_SUB;
            OP_AND, OP_ANDI: code = ALU_AND;
            OP_OR, OP_ORI:   code = ALU_OR;
            OP_SHR:          code = ALU_SHR;
            OP_SHL:          code = ALU_SHL;
            OP_ROR:          code = ALU_ROR;
            OP_ROL:          code = ALU_ROL;
            OP_MUL:          code = ALU_MUL;
            OP_DIV:          code = ALU_DIV;
            default:         code = ALU_ADD;
        endcase
        return code;
    endfunction

endpackage
`default_nettype wire

// File: rtl/control_unit_mem_handshake.sv
`default_nettype none
// ============================================================================
// mem_handshake -- request/ready completion tracking; CU_TIMEOUT_EN adds a wait-cycle timeout
// Rev 1.0
// ============================================================================
module mem_handshake #(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic req,
    input  logic ready,
    output logic done,
    output logic timeout
);

    assign done = req & ready;

`ifdef CU_TIMEOUT_EN
    localparam int CNT_W = $clog2(MEM_WAIT_MAX + 1);

    logic [CNT_W-1:0] wait_cnt;

    // Memory states are never back to back, so clearing while idle covers state entry.
    always_ff @(posedge clk) begin
        if (rst || !req || ready) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign timeout = req & ~ready & (wait_cnt == CNT_W'(MEM_WAIT_MAX - 1));
`else
    localparam int unused_wait_max = MEM_WAIT_MAX;
    logic unused_inputs;
    assign unused_inputs = clk ^ rst;
    assign timeout       = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
// control_unit -- Mini-SRC hardwired fetch/execute sequencer (CU_TIMEOUT_EN: memory timeout to FAULT)
// Rev 1.0
// ============================================================================
module control_unit #(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        in_reset,
    input  logic [31:0] in_ir,
    input  logic        in_mem_ready,
    output logic [8:0]  out_read_sel,
    output logic [9:0]  out_write_en,
    output logic [3:0]  out_regfile_location,
    output logic [3:0]  out_alu_opcode,
    output logic        out_mdr_select,
    output logic        out_inc_pc,
    output logic        out_BAout,
    output logic        out_reg_clear,
    output logic        out_mem_read,
    output logic        out_mem_write,
    output logic        out_instr_done,
    output logic        out_run,
    output logic        out_fault
);
    import cu_pkg::*;

    state_t state;

    logic [4:0] op;
    logic [3:0] ra, rb, rc;
    logic       is_alu, is_imm, is_addr, is_md;
    logic       rd_req, wr_req, mem_done, mem_timeout;
    logic       unused_ir;

    assign op = in_ir[31:27];
    assign ra = in_ir[26:23];
    assign rb = in_ir[22:19];
    assign rc = in_ir[18:15];
    assign unused_ir = ^in_ir[14:0];

    assign is_alu  = (op >= OP_ADD) && (op <= OP_ROL);
    assign is_imm  = (op >= OP_ADDI) && (op <= OP_ORI);
    assign is_addr = (op == OP_LD) || (op == OP_LDI) || (op == OP_ST);
    assign is_md   = (op == OP_MUL) || (op == OP_DIV);

    // Opcode is only trusted from T3 on, so the fetch read in T1 is decoded from state alone.
    assign rd_req = (state == ST_T1) || ((state == ST_T6) && (op == OP_LD));
    assign wr_req = (state == ST_T7) && (op == OP_ST);

    mem_handshake #(
        .MEM_WAIT_MAX (MEM_WAIT_MAX)
    ) u_mem_handshake (
        .clk     (clk),
        .rst     (in_reset),
        .req     (rd_req | wr_req),
        .ready   (in_mem_ready),
        .done    (mem_done),
        .timeout (mem_timeout)
    );

    always_ff @(posedge clk) begin
        if (in_reset) begin
            state <= ST_RESET;
        end else begin
            case (state)
                ST_RESET: state <= ST_T0;
                ST_T0:    state <= ST_T1;
                ST_T1: begin
                    if (mem_done)         state <= ST_T2;
                    else if (mem_timeout) state <= ST_FAULT;
                end
                ST_T2:    state <= ST_T3;
                ST_T3: begin
                    if (is_alu || is_imm || is_addr || is_md) state <= ST_T4;
                    else if (op == OP_HALT)                   state <= ST_HALT;
                    else if (op > OP_HALT)                    state <= ST_FAULT;
                    else                                      state <= ST_T0;
                end
                ST_T4:    state <= ST_T5;
                ST_T5: begin
                    if (is_md || (op == OP_LD) || (op == OP_ST)) state <= ST_T6;
                    else                                         state <= ST_T0;
                end
                ST_T6: begin
                    if (op == OP_LD) begin
                        if (mem_done)         state <= ST_T7;
                        else if (mem_timeout) state <= ST_FAULT;
                    end else if (op == OP_ST) begin
                        state <= ST_T7;
                    end else begin
                        state <= ST_T0;
                    end
                end
                ST_T7: begin
                    if (op == OP_ST) begin
                        if (mem_done)         state <= ST_T0;
                        else if (mem_timeout) state <= ST_FAULT;
                    end else begin
                        state <= ST_T0;
                    end
                end
                ST_HALT:  state <= ST_HALT;
                ST_FAULT: state <= ST_FAULT;
                default:  state <= ST_FAULT;
            endcase
        end
    end

    always_comb begin
        out_read_sel         = '0;
        out_write_en         = '0;
        out_regfile_location = '0;
        out_alu_opcode       = '0;
        out_mdr_select       = 1'b0;
        out_inc_pc           = 1'b0;
        out_BAout            = 1'b0;
        out_reg_clear        = 1'b0;
        out_mem_read         = rd_req;
        out_mem_write        = wr_req;
        out_instr_done       = 1'b0;
        out_run              = 1'b1;
        case (state)
            ST_RESET: out_reg_clear = 1'b1;
            ST_T0: begin
                out_read_sel[RS_PC]  = 1'b1;
                out_write_en[WE_MAR] = 1'b1;
                out_write_en[WE_PC]  = 1'b1;
                out_inc_pc           = 1'b1;
            end
            ST_T1: begin
                out_mdr_select       = 1'b1;
                out_write_en[WE_MDR] = mem_done;
            end
            ST_T2: begin
                out_read_sel[RS_MDR] = 1'b1;
                out_write_en[WE_IR]  = 1'b1;
            end
            ST_T3: begin
                if (is_alu || is_imm || is_addr) begin
                    out_read_sel[RS_REGFILE] = 1'b1;
                    out_regfile_location     = rb;
                    out_write_en[WE_Y]       = 1'b1;
                    out_BAout                = is_addr;
                end else if (is_md) begin
                    out_read_sel[RS_REGFILE] = 1'b1;
                    out_regfile_location     = ra;
                    out_write_en[WE_Y]       = 1'b1;
                end else begin
                    out_regfile_location = ra;
                    case (op)
                        OP_MFHI: begin
                            out_read_sel[RS_HI]      = 1'b1;
                            out_write_en[WE_REGFILE] = 1'b1;
                            out_instr_done           = 1'b1;
                        end
                        OP_MFLO: begin
                            out_read_sel[RS_LO]      = 1'b1;
                            out_write_en[WE_REGFILE] = 1'b1;
                            out_instr_done           = 1'b1;
                        end
                        OP_IN: begin
                            out_read_sel[RS_INPORT]  = 1'b1;
                            out_write_en[WE_REGFILE] = 1'b1;
                            out_instr_done           = 1'b1;
                        end
                        OP_OUT: begin
                            out_read_sel[RS_REGFILE] = 1'b1;
                            out_write_en[WE_OUTPORT] = 1'b1;
                            out_instr_done           = 1'b1;
                        end
                        OP_JR: begin
                            out_read_sel[RS_REGFILE] = 1'b1;
                            out_write_en[WE_PC]      = 1'b1;
                            out_instr_done           = 1'b1;
                        end
                        OP_NOP:  out_instr_done = 1'b1;
                        default: out_instr_done = 1'b0;
                    endcase
                end
            end
            ST_T4: begin
                if (is_md) begin
                    out_read_sel[RS_REGFILE] = 1'b1;
                    out_regfile_location     = rb;
                end else if (is_alu) begin
                    out_read_sel[RS_REGFILE] = 1'b1;
                    out_regfile_location     = rc;
                end else begin
                    out_read_sel[RS_C] = 1'b1;
                end
                out_alu_opcode     = alu_code(op);
                out_write_en[WE_Z] = 1'b1;
            end
            ST_T5: begin
                out_read_sel[RS_ZLO] = 1'b1;
                if (is_md) begin
                    out_write_en[WE_LO] = 1'b1;
                end else if ((op == OP_LD) || (op == OP_ST)) begin
                    out_write_en[WE_MAR] = 1'b1;
                end else begin
                    out_write_en[WE_REGFILE] = 1'b1;
                    out_regfile_location     = ra;
                    out_instr_done           = 1'b1;
                end
            end
            ST_T6: begin
                if (is_md) begin
                    out_read_sel[RS_ZHI] = 1'b1;
                    out_write_en[WE_HI]  = 1'b1;
                    out_instr_done       = 1'b1;
                end else if (op == OP_LD) begin
                    out_mdr_select       = 1'b1;
                    out_write_en[WE_MDR] = mem_done;
                end else begin
                    out_read_sel[RS_REGFILE] = 1'b1;
                    out_regfile_location     = ra;
                    out_write_en[WE_MDR]     = 1'b1;
                end
            end
            ST_T7: begin
                if (op == OP_ST) begin
                    out_instr_done = mem_done;
                end else begin
                    out_read_sel[RS_MDR]     = 1'b1;
                    out_write_en[WE_REGFILE] = 1'b1;
                    out_regfile_location     = ra;
                    out_instr_done           = 1'b1;
                end
            end
            default: out_run = 1'b0;
        endcase
    end

`ifdef CU_TIMEOUT_EN
    assign out_fault = (state == ST_FAULT);
`else
    assign out_fault = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_control_unit.sv
`default_nettype none
// ============================================================================
// tb_control_unit -- scoreboard bench for control_unit (CU_TIMEOUT_EN selects the timeout scenario)
// Rev 1.0
// ============================================================================
module tb_control_unit;

    logic        clk = 1'b0;
    logic        in_reset = 1'b1;
    logic [31:0] in_ir = '0;
    logic        in_mem_ready = 1'b0;
    logic [8:0]  out_read_sel;
    logic [9:0]  out_write_en;
    logic [3:0]  out_regfile_location;
    logic [3:0]  out_alu_opcode;
    logic        out_mdr_select, out_inc_pc, out_BAout, out_reg_clear;
    logic        out_mem_read, out_mem_write, out_instr_done, out_run, out_fault;

    always #5 clk = ~clk;

    control_unit #(.MEM_WAIT_MAX(15)) dut (
        .clk                  (clk),
        .in_reset             (in_reset),
        .in_ir                (in_ir),
        .in_mem_ready         (in_mem_ready),
        .out_read_sel         (out_read_sel),
        .out_write_en         (out_write_en),
        .out_regfile_location (out_regfile_location),
        .out_alu_opcode       (out_alu_opcode),
        .out_mdr_select       (out_mdr_select),
        .out_inc_pc           (out_inc_pc),
        .out_BAout            (out_BAout),
        .out_reg_clear        (out_reg_clear),
        .out_mem_read         (out_mem_read),
        .out_mem_write        (out_mem_write),
        .out_instr_done       (out_instr_done),
        .out_run              (out_run),
        .out_fault            (out_fault)
    );

    typedef struct packed {
        logic [8:0] rs;
        logic [9:0] we;
        logic [3:0] loc;
        logic [3:0] alu;
        logic [8:0] flags;
    } obs_t;

    typedef struct packed {
        logic rdy;
        obs_t exp;
    } sb_t;

    localparam logic [8:0] RS_C = 9'h100, RS_IN = 9'h080, RS_MDR = 9'h040, RS_PC = 9'h020;
    localparam logic [8:0] RS_ZLO = 9'h010, RS_ZHI = 9'h008, RS_LO = 9'h004, RS_HI = 9'h002, RS_RF = 9'h001;
    localparam logic [9:0] WE_OUT = 10'h200, WE_MAR = 10'h100, WE_Y = 10'h080, WE_IR = 10'h040, WE_MDR = 10'h020;
    localparam logic [9:0] WE_Z = 10'h010, WE_PC = 10'h008, WE_LO = 10'h004, WE_HI = 10'h002, WE_RF = 10'h001;
    localparam logic [8:0] F_MSEL = 9'h100, F_INC = 9'h080, F_BA = 9'h040, F_CLR = 9'h020, F_MRD = 9'h010;
    localparam logic [8:0] F_MWR = 9'h008, F_DONE = 9'h004, F_RUN = 9'h002, F_FLT = 9'h001;
`ifdef CU_TIMEOUT_EN
    localparam logic [8:0] F_FAULT_STATE = F_FLT;
`else
    localparam logic [8:0] F_FAULT_STATE = 9'h000;
`endif

    obs_t cur;
    assign cur = {out_read_sel, out_write_en, out_regfile_location, out_alu_opcode,
                  out_mdr_select, out_inc_pc, out_BAout, out_reg_clear,
                  out_mem_read, out_mem_write, out_instr_done, out_run, out_fault};

    int   n_checks = 0;
    int   n_fail   = 0;
    sb_t  q[$];

    function automatic obs_t mk(input logic [8:0] rs, input logic [9:0] we, input logic [3:0] loc,
                                input logic [3:0] alu, input logic [8:0] f);
        obs_t o;
        o = {rs, we, loc, alu, f};
        return o;
    endfunction

    // Address and ALU code only carry meaning while the strobes that consume them are active.
    function automatic obs_t norm(input obs_t o);
        obs_t r;
        r = o;
        if (!(r.rs[0] || r.we[0])) r.loc = '0;
        if (!r.we[4]) r.alu = '0;
        return r;
    endfunction

    function automatic logic [31:0] mkir(input logic [4:0] op, input logic [3:0] ra,
                                         input logic [3:0] rb, input logic [18:0] c);
        return {op, ra, rb, c};
    endfunction

    task automatic pm(input logic r, input obs_t e);
        sb_t s;
        s.rdy = r;
        s.exp = e;
        q.push_back(s);
    endtask

    task automatic pe(input obs_t e);
        pm(1'b1, e);
    endtask

    task automatic push_fetch(input int waits);
        pe(mk(RS_PC, WE_MAR | WE_PC, 4'd0, 4'd0, F_INC | F_RUN));
        repeat (waits) pm(1'b0, mk(9'h000, 10'h000, 4'd0, 4'd0, F_MRD | F_MSEL | F_RUN));
        pm(1'b1, mk(9'h000, WE_MDR, 4'd0, 4'd0, F_MRD | F_MSEL | F_RUN));
        pe(mk(RS_MDR, WE_IR, 4'd0, 4'd0, F_RUN));
    endtask

    task automatic test_reset();
        in_reset     = 1'b1;
        in_mem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (norm(cur) !== mk(9'h000, 10'h000, 4'd0, 4'd0, F_CLR | F_RUN)) begin
                n_fail++;
                $display("FAIL reset cycle %0d: observed %h, expected %h", i, norm(cur),
                         mk(9'h000, 10'h000, 4'd0, 4'd0, F_CLR | F_RUN));
            end
        end
        in_reset = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (norm(cur) !== mk(RS_PC, WE_MAR | WE_PC, 4'd0, 4'd0, F_INC | F_RUN)) begin
            n_fail++;
            $display("FAIL reset_release_t0: observed %h, expected %h", norm(cur),
                     mk(RS_PC, WE_MAR | WE_PC, 4'd0, 4'd0, F_INC | F_RUN));
        end
    endtask

    task automatic test_alu();
        sb_t        s;
        int         step;
        logic [31:0] irs [5];
        logic [3:0]  ra [5]    = '{4'd3, 4'd1, 4'd4, 4'd5, 4'd1};
        logic [3:0]  rb [5]    = '{4'd1, 4'd2, 4'd8, 4'd6, 4'd0};
        logic [3:0]  rc [5]    = '{4'd2, 4'd3, 4'd9, 4'd0, 4'd0};
        int          kind [5]  = '{0, 0, 0, 1, 2};
        logic [3:0]  alu [5]   = '{4'd0, 4'd1, 4'd7, 4'd2, 4'd0};
        int          waits [5] = '{0, 2, 0, 1, 0};
        irs[0] = 32'h1989_0000;
        irs[1] = mkir(5'd4, 4'd1, 4'd2, 19'(3 << 15));
        irs[2] = mkir(5'd10, 4'd4, 4'd8, 19'(9 << 15));
        irs[3] = mkir(5'd12, 4'd5, 4'd6, 19'h1F);
        irs[4] = mkir(5'd1, 4'd1, 4'd0, 19'd5);
        for (int i = 0; i < 5; i++) begin
            in_ir = irs[i];
            push_fetch(waits[i]);
            pe(mk(RS_RF, WE_Y, rb[i], 4'd0, ((kind[i] == 2) ? F_BA : 9'h000) | F_RUN));
            pe(mk((kind[i] == 0) ? RS_RF : RS_C, WE_Z, (kind[i] == 0) ? rc[i] : 4'd0, alu[i], F_RUN));
            pe(mk(RS_ZLO, WE_RF, ra[i], 4'd0, F_DONE | F_RUN));
            step = 0;
            while (q.size() > 0) begin
                s = q.pop_front();
                in_mem_ready = s.rdy;
                #1;
                n_checks++;
                if (norm(cur) !== norm(s.exp)) begin
                    n_fail++;
                    $display("FAIL alu instr %0d step %0d: observed %h, expected %h", i, step, norm(cur), norm(s.exp));
                end
                step++;
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic test_load_store();
        sb_t s;
        int  step;
        in_ir = 32'h0100_0065;
        push_fetch(0);
        pe(mk(RS_RF, WE_Y, 4'd0, 4'd0, F_BA | F_RUN));
        pe(mk(RS_C, WE_Z, 4'd0, 4'd0, F_RUN));
        pe(mk(RS_ZLO, WE_MAR, 4'd0, 4'd0, F_RUN));
        repeat (3) pm(1'b0, mk(9'h000, 10'h000, 4'd0, 4'd0, F_MRD | F_MSEL | F_RUN));
        pm(1'b1, mk(9'h000, WE_MDR, 4'd0, 4'd0, F_MRD | F_MSEL | F_RUN));
        pe(mk(RS_MDR, WE_RF, 4'd2, 4'd0, F_DONE | F_RUN));
        step = 0;
        while (q.size() > 0) begin
            s = q.pop_front();
            in_mem_ready = s.rdy;
            #1;
            n_checks++;
            if (norm(cur) !== norm(s.exp)) begin
                n_fail++;
                $display("FAIL ld step %0d: observed %h, expected %h", step, norm(cur), norm(s.exp));
            end
            step++;
            @(posedge clk);
            #1;
        end
        in_ir = mkir(5'd2, 4'd7, 4'd1, 19'h10);
        push_fetch(1);
        pe(mk(RS_RF, WE_Y, 4'd1, 4'd0, F_BA | F_RUN));
        pe(mk(RS_C, WE_Z, 4'd0, 4'd0, F_RUN));
        pe(mk(RS_ZLO, WE_MAR, 4'd0, 4'd0, F_RUN));
        pe(mk(RS_RF, WE_MDR, 4'd7, 4'd0, F_RUN));
        repeat (2) pm(1'b0, mk(9'h000, 10'h000, 4'd0, 4'd0, F_MWR | F_RUN));
        pm(1'b1, mk(9'h000, 10'h000, 4'd0, 4'd0, F_MWR | F_DONE | F_RUN));
        step = 0;
        while (q.size() > 0) begin
            s = q.pop_front();
            in_mem_ready = s.rdy;
            #1;
            n_checks++;
            if (norm(cur) !== norm(s.exp)) begin
                n_fail++;
                $display("FAIL st step %0d: observed %h, expected %h", step, norm(cur), norm(s.exp));
            end
            step++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_muldiv();
        sb_t s;
        int  step;
        for (int i = 0; i < 2; i++) begin
            logic [3:0] ra = (i == 0) ? 4'd4 : 4'd10;
            logic [3:0] rb = (i == 0) ? 4'd5 : 4'd11;
            in_ir = mkir((i == 0) ? 5'd14 : 5'd15, ra, rb, 19'd0);
            push_fetch(i);
            pe(mk(RS_RF, WE_Y, ra, 4'd0, F_RUN));
            pe(mk(RS_RF, WE_Z, rb, (i == 0) ? 4'd8 : 4'd9, F_RUN));
            pe(mk(RS_ZLO, WE_LO, 4'd0, 4'd0, F_RUN));
            pe(mk(RS_ZHI, WE_HI, 4'd0, 4'd0, F_DONE | F_RUN));
            step = 0;
            while (q.size() > 0) begin
                s = q.pop_front();
                in_mem_ready = s.rdy;
                #1;
                n_checks++;
                if (norm(cur) !== norm(s.exp)) begin
                    n_fail++;
                    $display("FAIL muldiv instr %0d step %0d: observed %h, expected %h", i, step, norm(cur), norm(s.exp));
                end
                step++;
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic test_short();
        sb_t        s;
        int         step;
        logic [4:0] op [6] = '{5'd17, 5'd18, 5'd19, 5'd20, 5'd16, 5'd21};
        logic [3:0] ra [6] = '{4'd6, 4'd7, 4'd2, 4'd3, 4'd9, 4'd0};
        logic [8:0] rs [6] = '{RS_HI, RS_LO, RS_IN, RS_RF, RS_RF, 9'h000};
        logic [9:0] we [6] = '{WE_RF, WE_RF, WE_RF, WE_OUT, WE_PC, 10'h000};
        for (int i = 0; i < 6; i++) begin
            in_ir = mkir(op[i], ra[i], 4'd0, 19'd0);
            push_fetch(i % 2);
            pe(mk(rs[i], we[i], ra[i], 4'd0, F_DONE | F_RUN));
            step = 0;
            while (q.size() > 0) begin
                s = q.pop_front();
                in_mem_ready = s.rdy;
                #1;
                n_checks++;
                if (norm(cur) !== norm(s.exp)) begin
                    n_fail++;
                    $display("FAIL short op %0d step %0d: observed %h, expected %h", op[i], step, norm(cur), norm(s.exp));
                end
                step++;
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic test_halt_fault();
        sb_t s;
        int  step;
        for (int i = 0; i < 2; i++) begin
            in_ir = mkir((i == 0) ? 5'd22 : 5'd31, 4'd1, 4'd2, 19'd0);
            push_fetch(0);
            pe(mk(9'h000, 10'h000, 4'd0, 4'd0, F_RUN));
            repeat (4) pe(mk(9'h000, 10'h000, 4'd0, 4'd0, (i == 0) ? 9'h000 : F_FAULT_STATE));
            step = 0;
            while (q.size() > 0) begin
                s = q.pop_front();
                in_mem_ready = s.rdy;
                #1;
                n_checks++;
                if (norm(cur) !== norm(s.exp)) begin
                    n_fail++;
                    $display("FAIL %s step %0d: observed %h, expected %h", (i == 0) ? "halt" : "bad_opcode",
                             step, norm(cur), norm(s.exp));
                end
                step++;
                @(posedge clk);
                #1;
            end
            test_reset();
        end
    endtask

    task automatic test_timeout();
        sb_t s;
        int  step;
        in_ir = mkir(5'd2, 4'd7, 4'd1, 19'h10);
        push_fetch(0);
        pe(mk(RS_RF, WE_Y, 4'd1, 4'd0, F_BA | F_RUN));
        pe(mk(RS_C, WE_Z, 4'd0, 4'd0, F_RUN));
        pe(mk(RS_ZLO, WE_MAR, 4'd0, 4'd0, F_RUN));
        pe(mk(RS_RF, WE_MDR, 4'd7, 4'd0, F_RUN));
`ifdef CU_TIMEOUT_EN
        repeat (15) pm(1'b0, mk(9'h000, 10'h000, 4'd0, 4'd0, F_MWR | F_RUN));
        repeat (3) pm(1'b0, mk(9'h000, 10'h000, 4'd0, 4'd0, F_FLT));
`else
        repeat (20) pm(1'b0, mk(9'h000, 10'h000, 4'd0, 4'd0, F_MWR | F_RUN));
`endif
        step = 0;
        while (q.size() > 0) begin
            s = q.pop_front();
            in_mem_ready = s.rdy;
            #1;
            n_checks++;
            if (norm(cur) !== norm(s.exp)) begin
                n_fail++;
                $display("FAIL timeout step %0d: observed %h, expected %h", step, norm(cur), norm(s.exp));
            end
            step++;
            @(posedge clk);
            #1;
        end
        test_reset();
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_store();
        test_muldiv();
        test_short();
        test_halt_fault();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no completion by time limit, required completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
